// File: rtl/mult_div_seq.sv
// Sequential unsigned multiply (shift-add) / divide (restoring) unit, one bit per clock.
// INIT/DONE handshake; divide-by-zero short-circuits to FIN with a flagged result.
module mult_div_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               INIT,
    input  logic               MODE,
    input  logic [WIDTH-1:0]   ENTRADA_A,
    input  logic [WIDTH-1:0]   ENTRADA_B,
    output logic               BUSY,
    output logic               DONE,
    output logic               DIV_ZERO,
    output logic [2*WIDTH-1:0] RESULTADO
);

    localparam int RW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic               mode_r, mode_s;
    logic [RW-1:0]      mcand_r, mcand_s;
    logic [WIDTH-1:0]   opb_r, opb_s;
    logic [RW-1:0]      acc_r, acc_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [RW-1:0]      result_r, result_s;
    logic               div_zero_r, div_zero_s;
    logic               busy_r, done_r;

    logic [RW-1:0]      acc_mul_s;
    logic [RW-1:0]      acc_div_s;
    logic [WIDTH:0]     rem_sh_s;
    logic [WIDTH:0]     trial_s;

    // One iteration of each datapath; acc_r holds {remainder, dividend/quotient} while dividing.
    always_comb begin
        acc_mul_s = acc_r + (opb_r[0] ? mcand_r : {RW{1'b0}});
        rem_sh_s  = acc_r[RW-1:WIDTH-1];
        // Remainder stays below the divisor, so bit WIDTH of the difference is its sign.
        trial_s   = rem_sh_s - {1'b0, opb_r};
        if (trial_s[WIDTH] == 1'b0) begin
            acc_div_s = {trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end else begin
            acc_div_s = {rem_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        state_s    = state_r;
        mode_s     = mode_r;
        mcand_s    = mcand_r;
        opb_s      = opb_r;
        acc_s      = acc_r;
        cnt_s      = cnt_r;
        result_s   = result_r;
        div_zero_s = div_zero_r;
        case (state_r)
            IDLE: begin
                if (INIT) begin
                    mode_s  = MODE;
                    mcand_s = {{WIDTH{1'b0}}, ENTRADA_A};
                    opb_s   = ENTRADA_B;
                    cnt_s   = CNT_LOAD;
                    if (MODE) begin
                        acc_s = {{WIDTH{1'b0}}, ENTRADA_A};
                    end else begin
                        acc_s = {RW{1'b0}};
                    end
                    if (MODE && (ENTRADA_B == {WIDTH{1'b0}})) begin
                        result_s   = {ENTRADA_A, {WIDTH{1'b1}}};
                        div_zero_s = 1'b1;
                        state_s    = FIN;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                cnt_s = cnt_r - CNT_ONE;
                if (mode_r) begin
                    acc_s = acc_div_s;
                end else begin
                    acc_s   = acc_mul_s;
                    mcand_s = mcand_r << 1;
                    opb_s   = opb_r >> 1;
                end
                if (cnt_r == CNT_ONE) begin
                    result_s   = mode_r ? acc_div_s : acc_mul_s;
                    div_zero_s = 1'b0;
                    state_s    = FIN;
                end else begin
                    state_s = RUN;
                end
            end
            FIN: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; reset clears everything and beats INIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            mode_r     <= 1'b0;
            mcand_r    <= {RW{1'b0}};
            opb_r      <= {WIDTH{1'b0}};
            acc_r      <= {RW{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            result_r   <= {RW{1'b0}};
            div_zero_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            mode_r     <= mode_s;
            mcand_r    <= mcand_s;
            opb_r      <= opb_s;
            acc_r      <= acc_s;
            cnt_r      <= cnt_s;
            result_r   <= result_s;
            div_zero_r <= div_zero_s;
            busy_r     <= (state_s == RUN);
            done_r     <= (state_s == FIN);
        end
    end

    assign BUSY      = busy_r;
    assign DONE      = done_r;
    assign DIV_ZERO  = div_zero_r;
    assign RESULTADO = result_r;

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed bench for mult_div_seq (WIDTH=16 and WIDTH=8) with a queue-based scoreboard.
module tb_mult_div_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        init16, mode16, busy16, done16, dz16;
    logic [15:0] a16, b16;
    logic [31:0] res16;
    logic        init8, mode8, busy8, done8, dz8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;

    typedef struct {
        logic [31:0] res;
        logic        dz;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mult_div_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .INIT(init16), .MODE(mode16),
        .ENTRADA_A(a16), .ENTRADA_B(b16), .BUSY(busy16), .DONE(done16),
        .DIV_ZERO(dz16), .RESULTADO(res16)
    );

    mult_div_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .INIT(init8), .MODE(mode8),
        .ENTRADA_A(a8), .ENTRADA_B(b8), .BUSY(busy8), .DONE(done8),
        .DIV_ZERO(dz8), .RESULTADO(res8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model16(input logic [15:0] a, input logic [15:0] b, input logic m);
        exp_t e;
        if (!m) begin
            e.res = 32'(a) * 32'(b);
            e.dz  = 1'b0;
        end else if (b == 16'd0) begin
            e.res = {a, 16'hFFFF};
            e.dz  = 1'b1;
        end else begin
            e.res = {a % b, a / b};
            e.dz  = 1'b0;
        end
        return e;
    endfunction

    function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.res = {16'h0000, a % b, a / b};
        e.dz  = 1'b0;
        return e;
    endfunction

    task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic m, input int exp_lat);
        exp_t e;
        int   lat;
        int   busy_n;
        bit   got;
        sb_q.push_back(model16(a, b, m));
        @(negedge clk);
        a16 = a; b16 = b; mode16 = m; init16 = 1'b1;
        @(posedge clk);
        #1 init16 = 1'b0;
        got = 1'b0; lat = -1; busy_n = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (done16) begin
                got = 1'b1;
                lat = k;
            end else if (busy16) begin
                busy_n++;
            end
        end
        e = sb_q.pop_front();
        check({tag, " done_seen"}, 64'(got), 64'd1);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " busy_cycles"}, 64'(busy_n), 64'(exp_lat));
        check({tag, " result"}, 64'(res16), 64'(e.res));
        check({tag, " div_zero"}, 64'(dz16), 64'(e.dz));
        @(negedge clk);
        check({tag, " done_width"}, 64'(done16), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        bit   saw_done;
        int   ndone;
        int   lat8;

        reset = 1'b1;
        init16 = 1'b0; mode16 = 1'b0; a16 = 16'd0; b16 = 16'd0;
        init8  = 1'b0; mode8  = 1'b0; a8  = 8'd0;  b8  = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", 64'(busy16), 64'd0);
        check("reset done", 64'(done16), 64'd0);
        check("reset div_zero", 64'(dz16), 64'd0);
        check("reset result16", 64'(res16), 64'd0);
        check("reset result8", 64'(res8), 64'd0);
        reset = 1'b0;

        op16("mul_300x200", 16'd300, 16'd200, 1'b0, 16);
        op16("mul_ffffxffff", 16'hFFFF, 16'hFFFF, 1'b0, 16);
        op16("div_1000by7", 16'd1000, 16'd7, 1'b1, 16);
        op16("div_by_zero", 16'd1234, 16'd0, 1'b1, 0);
        op16("mul_zero_a", 16'd0, 16'd5, 1'b0, 16);
        op16("div_a_lt_b", 16'd5, 16'd9, 1'b1, 16);
        op16("div_max", 16'hFFFF, 16'h0001, 1'b1, 16);

        // Reset eight cycles into a multiply aborts it.
        @(negedge clk);
        a16 = 16'd77; b16 = 16'd99; mode16 = 1'b0; init16 = 1'b1;
        @(posedge clk);
        #1 init16 = 1'b0;
        saw_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            saw_done = saw_done | done16;
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort no_done", 64'(saw_done), 64'd0);
        check("abort busy", 64'(busy16), 64'd0);
        check("abort done", 64'(done16), 64'd0);
        check("abort result", 64'(res16), 64'd0);
        op16("mul_after_reset", 16'd77, 16'd99, 1'b0, 16);

        // INIT held high for three back-to-back operations.
        sb_q.push_back(model16(16'd1234, 16'd567, 1'b0));
        sb_q.push_back(model16(16'd50000, 16'd123, 1'b1));
        sb_q.push_back(model16(16'hABCD, 16'h1234, 1'b0));
        @(negedge clk);
        a16 = 16'd1234; b16 = 16'd567; mode16 = 1'b0; init16 = 1'b1;
        @(posedge clk);
        #1;
        ndone = 0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (k == 5) begin
                a16 = 16'd50000; b16 = 16'd123; mode16 = 1'b1;
            end
            if (k == 23) begin
                a16 = 16'hABCD; b16 = 16'h1234; mode16 = 1'b0;
            end
            if (k == 36) begin
                init16 = 1'b0; a16 = 16'hDEAD; b16 = 16'h0000; mode16 = 1'b1;
            end
            if (done16) begin
                if (sb_q.size() == 0) begin
                    check("b2b extra_done", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("b2b done_cycle", 64'(k), 64'(16 + 18 * ndone));
                    check("b2b result", 64'(res16), 64'(e.res));
                    check("b2b div_zero", 64'(dz16), 64'(e.dz));
                    ndone++;
                end
            end
        end
        check("b2b done_count", 64'(ndone), 64'd3);
        sb_q.delete();

        // WIDTH=8 divide.
        sb_q.push_back(model8(8'd200, 8'd13));
        @(negedge clk);
        a8 = 8'd200; b8 = 8'd13; mode8 = 1'b1; init8 = 1'b1;
        @(posedge clk);
        #1 init8 = 1'b0;
        lat8 = -1;
        for (int k = 0; k < 30 && lat8 < 0; k++) begin
            @(negedge clk);
            if (done8) begin
                lat8 = k;
            end
        end
        e = sb_q.pop_front();
        check("w8 latency", 64'(lat8), 64'd8);
        check("w8 result", 64'(res8), 64'(e.res));
        check("w8 result_const", 64'(res8), 64'h050F);
        check("w8 div_zero", 64'(dz8), 64'(e.dz));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
